// File: rtl/template_pkg.sv
// Shared defaults, counter width and framer state type for the template output path.
package template_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_FRAME_LEN  = 8;
    localparam int CNT_WIDTH      = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } framer_state_t;
endpackage

// File: rtl/template_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is presented on dout while not empty.
module template_sync_fifo
    import template_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [LW-1:0]         fill_level,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_count;
    logic                  w_rd;
    logic                  w_wr;

    assign empty      = (r_count == '0);
    assign full       = (r_count == LW'(DEPTH));
    assign fill_level = r_count;
    assign dout       = empty ? '0 : r_mem[r_rd_ptr];

    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign w_rd = rd_en & ~empty;
    assign w_wr = wr_en & (~full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/template_output_framer.sv
// Buffers the template word stream and emits fixed-length frames with last/error marking,
// counting completed frames and dropped words.
module template_output_framer
    import template_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    localparam int LW = $clog2(FIFO_DEPTH + 1),
    localparam int BW = $clog2(FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] output_data,
    input  logic                  output_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_err,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [LW-1:0]         fill_level,
    output logic [CNT_WIDTH-1:0]  overflow_count
);
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    framer_state_t         r_state;
    logic [BW-1:0]         r_beat_cnt;
    logic                  r_frame_drop;
    logic [CNT_WIDTH-1:0]  r_frame_count;
    logic [CNT_WIDTH-1:0]  r_overflow_count;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_last;
    logic                  w_full;
    logic                  w_empty;
    logic [LW-1:0]         w_fill;
    logic [DATA_WIDTH-1:0] w_dout;

    template_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (w_wr),
        .rd_en      (w_rd),
        .din        (output_data),
        .dout       (w_dout),
        .fill_level (w_fill),
        .full       (w_full),
        .empty      (w_empty)
    );

    assign m_valid = ~w_empty;
    assign m_data  = w_dout;
    assign w_rd    = m_valid & m_ready;
    assign w_wr    = output_valid & (~w_full | w_rd);
    assign w_drop  = output_valid & ~w_wr;
    assign w_last  = m_valid & (r_beat_cnt == BW'(FRAME_LEN - 1));
    assign m_last  = w_last;
    // A drop coincident with the closing beat still belongs to the closing frame.
    assign m_err   = w_last & (r_frame_drop | w_drop);

    assign frame_count    = r_frame_count;
    assign fill_level     = w_fill;
    assign overflow_count = r_overflow_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_beat_cnt       <= '0;
            r_frame_drop     <= 1'b0;
            r_frame_count    <= '0;
            r_overflow_count <= '0;
        end else begin
            if (w_rd) begin
                case (r_state)
                    IDLE: begin
                        r_beat_cnt <= BW'(1);
                        r_state    <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (w_last) begin
                            r_beat_cnt <= '0;
                            r_state    <= IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
            if (w_rd & w_last) begin
                r_frame_count <= r_frame_count + CNT_WIDTH'(1);
                r_frame_drop  <= 1'b0;
            end else if (w_drop) begin
                r_frame_drop <= 1'b1;
            end
            if (w_drop) r_overflow_count <= sat_inc(r_overflow_count);
        end
    end
endmodule

// File: doc/template_output_framer.md
Name: template_output_framer

Overview:
- Downstream stage of the template block; consumes its output_data word stream.
- Buffers words in a synchronous FIFO and emits them on a valid/ready master interface, grouped into fixed-length frames with a last marker.
- Counts dropped words and flags any frame that lost data.
- Its output feeds the result-capture side of the datapath (template_result_intf consumers).

Parameters:
- DATA_WIDTH, 16, width of output_data and m_data.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- FRAME_LEN, 8, beats per frame; at least 2.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- output_data  input  DATA_WIDTH  word from template.
- output_valid  input  1  output_data is valid this cycle; no backpressure to template.
- m_data  output  DATA_WIDTH  FIFO head word.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accepts the current beat.
- m_last  output  1  current beat is the final beat of a frame.
- m_err  output  1  valid only with m_last; the frame had at least one dropped input word.
- frame_count  output  16  completed frames; wraps at 0xFFFF to 0.
- fill_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow_count  output  16  dropped words; saturates at 0xFFFF.

Behaviour:
- Reset: all pointers and counters go to 0, the FSM goes to IDLE and the drop flag clears. Reset value of every output is 0; m_data is 0 while empty. Reset asserted mid-frame discards the FIFO contents and the partial frame, with no m_last emitted.
- Write rule: a write occurs when output_valid=1 and (fill_level<FIFO_DEPTH or a read happens in the same cycle).
  - Otherwise the word is dropped.
  - overflow_count increments, saturating.
  - frame_drop is set.
- Read rule: a read occurs when m_valid=1 and m_ready=1.
- FIFO is first-word-fall-through.
  - m_valid = (fill_level!=0); m_data = mem[rd_ptr].
  - Write-to-m_valid latency: a word written at edge k is visible from edge k onward, i.e. 1 cycle.
  - There is no same-cycle bypass when empty.
- Simultaneous read and write: fill_level is unchanged, both pointers advance, and pointers wrap modulo FIFO_DEPTH.
- m_data, m_last and m_err are held stable while m_valid=1 and m_ready=0.
- Beat counter beat_cnt (width $clog2(FRAME_LEN)):
  - increments on each read;
  - m_last = m_valid and (beat_cnt==FRAME_LEN-1);
  - on a read with m_last, beat_cnt returns to 0 and frame_count increments.
- FSM states:
  - IDLE: beat_cnt=0, no frame in progress. The first read moves the FSM to ACTIVE.
  - ACTIVE: a frame is partially transferred. A read with m_last returns the FSM to IDLE.
- Drop flag frame_drop is set by any drop while in IDLE or ACTIVE.
  - m_err = m_last and (frame_drop or a drop in the current cycle).
  - frame_drop clears on the m_last read. A drop in that same cycle is charged to the closing frame and does not carry over.
- All outputs are registered, except m_valid, m_data, m_last and m_err, which are combinational from registered state.

Decomposition:
- Package template_pkg holds:
  - DATA_WIDTH, FIFO_DEPTH and FRAME_LEN defaults;
  - the framer_state_t enum {IDLE, ACTIVE};
  - the CNT_WIDTH=16 constant.
- One sub-module, template_sync_fifo: single-clock FWFT FIFO with wr_en, rd_en, din, dout, fill_level, full and empty. The framer FSM, counters and drop logic stay in the top module.

Test Plan:
- Burst of 8 words 0x0001..0x0008 with m_ready=1 → 8 beats in order, m_last only on 0x0008, m_err=0, frame_count=1, fill_level returns to 0.
- m_ready=0 while 20 consecutive words are written → fill_level=16 and overflow_count=4. Releasing m_ready then gives two frames carrying the first 16 words. Frame 1 has m_err=1, because the drops occurred while the FSM was IDLE and were attributed to the first frame. frame_count=2.
- FIFO full, with output_valid=1 and m_ready=1 in the same cycle → no drop, fill_level stays 16, and the order is preserved across pointer wrap.
- m_ready toggled every other cycle during a 16-word stream → each beat is held stable while stalled, m_last appears on beats 8 and 16, and there is no duplication or loss.
- Reset asserted for 1 cycle after 3 beats of a frame are read → all outputs are 0 the next cycle. The next 8 words form a clean frame with m_err=0 and frame_count=1.
- Preload frame_count to 0xFFFF via 65535 frames, or force in the bench, then complete one frame → frame_count=0x0000. With overflow_count forced to 0xFFFF, one more drop leaves it at 0xFFFF.
